// File: rtl/mire_if.sv
// Wishbone master-side bundle used by the test-grid writer.
interface wshb_if;
   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic        ack;

   modport master (
      input  clk, rst, ack,
      output cyc, stb, we, sel, cti, bte, adr, dat_ms
   );
endinterface

// File: rtl/mire.sv
// Wishbone write master that paints a white grid on black into the framebuffer,
// yielding the bus for one cycle after every BURST accepted writes.
module mire #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int GRID  = 16,
   parameter int BURST = 64
) (
   wshb_if.master wshb_ifm,
   output logic   frame_done
);
   localparam int NPIX = HDISP * VDISP;
   localparam int PW   = (NPIX  > 1) ? $clog2(NPIX)  : 1;
   localparam int XW   = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int YW   = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int BW   = (BURST > 1) ? $clog2(BURST) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
   localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

   typedef enum logic {WRITE = 1'b0, PAUSE = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [PW-1:0]   pixel_id_q, pixel_id_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            frame_done_q, frame_done_d;
   logic            active;
   logic            done;
   logic            on_grid;

   // Reset gates the strobe combinationally so an in-flight access is dropped at once.
   assign active  = (state_q == WRITE) && !wshb_ifm.rst;
   assign done    = active && wshb_ifm.ack;
   assign on_grid = ((32'(x_q) & 32'(GRID - 1)) == 32'd0) ||
                    ((32'(y_q) & 32'(GRID - 1)) == 32'd0);

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      pixel_id_d   = pixel_id_q;
      burst_cnt_d  = burst_cnt_q;
      frame_done_d = 1'b0;

      case (state_q)
         WRITE: begin
            if (done) begin
               if (burst_cnt_q == B_LAST) begin
                  burst_cnt_d = '0;
                  state_d     = PAUSE;
               end else begin
                  burst_cnt_d = burst_cnt_q + 1'b1;
               end
            end
         end
         PAUSE:   state_d = WRITE;
         default: state_d = WRITE;
      endcase

      if (done) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
         if (pixel_id_q == P_LAST) begin
            pixel_id_d   = '0;
            frame_done_d = 1'b1;
         end else begin
            pixel_id_d = pixel_id_q + 1'b1;
         end
      end
   end

   always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
      if (wshb_ifm.rst) begin
         state_q      <= WRITE;
         x_q          <= '0;
         y_q          <= '0;
         pixel_id_q   <= '0;
         burst_cnt_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         pixel_id_q   <= pixel_id_d;
         burst_cnt_q  <= burst_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wshb_ifm.cyc    = active;
   assign wshb_ifm.stb    = active;
   assign wshb_ifm.we     = 1'b1;
   assign wshb_ifm.sel    = 4'hF;
   assign wshb_ifm.cti    = 3'b000;
   assign wshb_ifm.bte    = 2'b00;
   assign wshb_ifm.adr    = 32'(pixel_id_q) << 2;
   assign wshb_ifm.dat_ms = on_grid ? 32'h00FF_FFFF : 32'h0000_0000;
   assign frame_done      = frame_done_q;
endmodule

// File: tb/tb_mire.sv
// Scoreboard bench for the test-grid writer on a 32x8 frame with 64-write bursts.
module tb_mire;
   wshb_if wshb();
   logic   frame_done;

   mire #(.HDISP(32), .VDISP(8), .GRID(16), .BURST(64)) dut (
      .wshb_ifm   (wshb),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   acc_cnt = 0;
   logic fd_exp    = 1'b0;
   logic pause_exp = 1'b0;
   logic accepted;
   wr_t  cur;

   initial wshb.clk = 1'b0;
   always #5 wshb.clk = ~wshb.clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Hand-derived grid for 32x8, pitch 16: white on columns 0 and 16 and on row 0.
   function automatic logic [31:0] grid_dat(input int k);
      int x;
      int y;
      x = k % 32;
      y = (k / 32) % 8;
      return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
   endfunction

   task automatic push_pixels(input int n);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         e.adr = 32'((i % 256) * 4);
         e.dat = grid_dat(i % 256);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_q_size(input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(posedge wshb.clk);
         #1;
         if (exp_q.size() == target) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, queue size %0d, required %0d", name, exp_q.size(), target);
   endtask

   // Monitor: samples on the falling edge, where stb/ack/adr are settled for the next rising edge.
   always @(negedge wshb.clk) begin
      if (wshb.rst) begin
         check("rst_cyc", 32'(wshb.cyc), 32'd0);
         check("rst_stb", 32'(wshb.stb), 32'd0);
         check("rst_frame_done", 32'(frame_done), 32'd0);
         acc_cnt   = 0;
         fd_exp    = 1'b0;
         pause_exp = 1'b0;
      end else begin
         check("frame_done", 32'(frame_done), 32'(fd_exp));
         check("cyc", 32'(wshb.cyc), 32'(!pause_exp));
         check("stb", 32'(wshb.stb), 32'(!pause_exp));
         accepted  = wshb.stb && wshb.ack;
         fd_exp    = 1'b0;
         pause_exp = 1'b0;
         if (wshb.stb && exp_q.size() > 0) begin
            check("adr", wshb.adr, exp_q[0].adr);
            check("dat_ms", wshb.dat_ms, exp_q[0].dat);
         end
         if (accepted) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got adr 0x%08h, required no write", wshb.adr);
            end else begin
               cur = exp_q.pop_front();
               check("we", 32'(wshb.we), 32'd1);
               check("sel", 32'(wshb.sel), 32'hF);
               check("cti", 32'(wshb.cti), 32'd0);
               check("bte", 32'(wshb.bte), 32'd0);
               acc_cnt++;
               $display("[TB] write #%0d adr=0x%08h dat=0x%08h", acc_cnt, wshb.adr, wshb.dat_ms);
               fd_exp    = (cur.adr == 32'h0000_03FC);
               pause_exp = (acc_cnt % 64 == 0);
            end
         end
      end
   end

   initial begin
      bit found;
      wshb.rst = 1'b0;
      wshb.ack = 1'b0;
      #1 wshb.rst = 1'b1;
      repeat (3) @(posedge wshb.clk);
      #1;
      // Two full frames plus pixels 0..128 of the third; reset lands on pixel 128 (adr 0x200).
      push_pixels(641);
      wshb.rst = 1'b0;
      wshb.ack = 1'b1;

      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge wshb.clk);
         #1;
         if (wshb.stb && wshb.adr == 32'h40) found = 1'b1;
      end
      check("reach_adr_40", 32'(found), 32'd1);
      wshb.ack = 1'b0;
      repeat (5) @(posedge wshb.clk);
      #1 wshb.ack = 1'b1;

      wait_q_size(1, 2000, "reach_adr_200");
      check("pre_reset_adr", wshb.adr, 32'h200);
      #2 wshb.rst = 1'b1;
      #1;
      check("async_rst_cyc", 32'(wshb.cyc), 32'd0);
      check("async_rst_stb", 32'(wshb.stb), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge wshb.clk);
      #1;
      push_pixels(130);
      wshb.rst = 1'b0;

      wait_q_size(0, 400, "post_reset_writes");
      wshb.ack = 1'b0;
      repeat (3) @(posedge wshb.clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
